// File: rtl/sa_1d_feeder.sv
// Feeder for the 3-tap 1-D systolic array: loads weights, builds sliding
// windows and drives the PE inputs with one-cycle-per-stage skew.
module sa_1d_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  sa_valid_in,
  output logic [DATA_WIDTH-1:0] sa_data_in0,
  output logic [DATA_WIDTH-1:0] sa_data_in1,
  output logic [DATA_WIDTH-1:0] sa_data_in2,
  output logic [DATA_WIDTH-1:0] sa_weight_in0,
  output logic [DATA_WIDTH-1:0] sa_weight_in1,
  output logic [DATA_WIDTH-1:0] sa_weight_in2,
  output logic [PSUM_WIDTH-1:0] sa_psum_in,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, FILL, RUN, DRAIN
  } state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  n;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [1:0]            wcnt;
  logic [DATA_WIDTH-1:0] win0;
  logic [DATA_WIDTH-1:0] win1;
  logic [DATA_WIDTH-1:0] tap1;
  logic [DATA_WIDTH-1:0] tap2a;
  logic [DATA_WIDTH-1:0] tap2b;
  logic                  v1;
  logic                  w_hs;
  logic                  x_hs;
  logic                  issue;

  assign w_hs       = w_valid & w_ready;
  assign x_hs       = x_valid & x_ready;
  assign issue      = x_hs & (state == RUN);
  assign sa_psum_in = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      n             <= '0;
      cnt           <= '0;
      wcnt          <= '0;
      win0          <= '0;
      win1          <= '0;
      tap1          <= '0;
      tap2a         <= '0;
      tap2b         <= '0;
      v1            <= 1'b0;
      w_ready       <= 1'b0;
      x_ready       <= 1'b0;
      sa_valid_in   <= 1'b0;
      sa_data_in0   <= '0;
      sa_data_in1   <= '0;
      sa_data_in2   <= '0;
      sa_weight_in0 <= '0;
      sa_weight_in1 <= '0;
      sa_weight_in2 <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      // skew pipe: taps 1 and 2 trail tap 0 by one and two cycles
      sa_valid_in <= issue;
      sa_data_in0 <= issue ? win0 : '0;
      if (issue) begin
        tap1  <= win1;
        tap2a <= x_data;
      end
      tap2b       <= tap2a;
      v1          <= sa_valid_in;
      sa_data_in1 <= sa_valid_in ? tap1 : '0;
      sa_data_in2 <= v1 ? tap2b : '0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length >= LEN_WIDTH'(3)) begin
              n       <= length;
              wcnt    <= '0;
              busy    <= 1'b1;
              w_ready <= 1'b1;
              state   <= LOAD_W;
            end else begin
              done <= 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (w_hs) begin
            case (wcnt)
              2'd0:    sa_weight_in0 <= w_data;
              2'd1:    sa_weight_in1 <= w_data;
              default: sa_weight_in2 <= w_data;
            endcase
            if (wcnt == 2'd2) begin
              cnt     <= '0;
              w_ready <= 1'b0;
              x_ready <= 1'b1;
              state   <= FILL;
            end else begin
              wcnt <= wcnt + 2'd1;
            end
          end
        end
        FILL: begin
          if (x_hs) begin
            win0 <= win1;
            win1 <= x_data;
            cnt  <= cnt + LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1))
              state <= RUN;
          end
        end
        RUN: begin
          if (x_hs) begin
            win0 <= win1;
            win1 <= x_data;
            cnt  <= cnt + LEN_WIDTH'(1);
            if (cnt == n - LEN_WIDTH'(1)) begin
              x_ready <= 1'b0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // last window's tap 2 is being presented now; nothing left behind it
          if (!sa_valid_in && !v1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_1d_feeder.sv
// Directed bench for sa_1d_feeder with a small behavioural model of the
// 3-PE array hung off its outputs to recover psum values.
module tb_sa_1d_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] length;
  logic       w_valid;
  logic       w_ready;
  logic [7:0] w_data;
  logic       x_valid;
  logic       x_ready;
  logic [7:0] x_data;
  logic       sa_valid_in;
  logic [7:0] sa_data_in0, sa_data_in1, sa_data_in2;
  logic [7:0] sa_weight_in0, sa_weight_in1, sa_weight_in2;
  logic [15:0] sa_psum_in;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic       log_v[4096];
  logic [7:0] log_d0[4096];
  logic [7:0] log_d1[4096];
  logic [7:0] log_d2[4096];
  logic       log_done[4096];
  logic       log_busy[4096];

  logic [15:0] pp0, pp1, pp2;
  logic        pv0, pv1, pv2;
  logic [15:0] pq[$];

  sa_1d_feeder dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .sa_valid_in(sa_valid_in),
    .sa_data_in0(sa_data_in0), .sa_data_in1(sa_data_in1),
    .sa_data_in2(sa_data_in2),
    .sa_weight_in0(sa_weight_in0), .sa_weight_in1(sa_weight_in1),
    .sa_weight_in2(sa_weight_in2),
    .sa_psum_in(sa_psum_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    log_v[cyc % 4096]    = sa_valid_in;
    log_d0[cyc % 4096]   = sa_data_in0;
    log_d1[cyc % 4096]   = sa_data_in1;
    log_d2[cyc % 4096]   = sa_data_in2;
    log_done[cyc % 4096] = done;
    log_busy[cyc % 4096] = busy;
  end

  // array model: each PE adds its product one cycle after the previous PE
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pp0 <= '0; pp1 <= '0; pp2 <= '0;
      pv0 <= 1'b0; pv1 <= 1'b0; pv2 <= 1'b0;
    end else begin
      pp0 <= sa_valid_in ? 16'(sa_data_in0) * 16'(sa_weight_in0) : 16'd0;
      pv0 <= sa_valid_in;
      pp1 <= pp0 + 16'(sa_data_in1) * 16'(sa_weight_in1);
      pv1 <= pv0;
      pp2 <= pp1 + 16'(sa_data_in2) * 16'(sa_weight_in2);
      pv2 <= pv1;
      if (pv2) pq.push_back(pp2);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input int n, input bit gaps,
                         input bit noise, input int stop_at,
                         output int last_acc);
    int idx;
    int guard;
    bit hs;
    bit tog;
    last_acc = 0;
    start = 1'b1;
    length = 8'(n);
    tick(1);
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 3 && guard < 50) begin
      w_valid = 1'b1;
      w_data = (idx == 0) ? a : (idx == 1) ? b : c;
      hs = w_ready;
      tick(1);
      if (hs) idx++;
      guard++;
    end
    w_valid = 1'b0;
    n_cmp++;
    if (idx != 3) begin
      n_err++;
      $display("FAIL w_load_timeout: loaded %0d weights, required 3", idx);
    end
    idx = 0;
    guard = 0;
    tog = 1'b1;
    while (idx < stop_at && guard < 2000) begin
      x_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      x_data = 8'(idx + 1);
      start = noise;
      length = 8'd3;
      w_valid = noise;
      w_data = 8'hEE;
      hs = x_valid && x_ready;
      if (hs) last_acc = cyc;
      tick(1);
      if (hs) idx++;
      guard++;
    end
    x_valid = 1'b0;
    start = 1'b0;
    w_valid = 1'b0;
    n_cmp++;
    if (idx != stop_at) begin
      n_err++;
      $display("FAIL x_feed_timeout: accepted %0d samples, required %0d",
               idx, stop_at);
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({sa_valid_in, sa_data_in0, sa_data_in1, sa_data_in2, sa_weight_in0,
         sa_weight_in1, sa_weight_in2, sa_psum_in, busy, done, w_ready,
         x_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: some output nonzero during reset");
    end
    tick(1);
    rst = 1'b0;
    tick(2);
    n_cmp++;
    if ({busy, w_ready, x_ready, done} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b required 0000",
               {busy, w_ready, x_ready, done});
    end
  endtask

  task automatic test_back_to_back;
    int c;
    int t0;
    int nd;
    logic [7:0] e0[3] = '{8'd1, 8'd2, 8'd3};
    t0 = cyc;
    pq.delete();
    run_job(8'd1, 8'd2, 8'd3, 5, 1'b0, 1'b0, 5, c);
    tick(8);
    n_cmp++;
    if (!(log_v[c-2] == 0 && log_v[c-1] == 1 && log_v[c] == 1 &&
          log_v[c+1] == 1 && log_v[c+2] == 0)) begin
      n_err++;
      $display("FAIL b2b_valid: got %b%b%b%b%b required 01110",
               log_v[c-2], log_v[c-1], log_v[c], log_v[c+1], log_v[c+2]);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (log_d0[c-1+k] !== e0[k] || log_d1[c+k] !== e0[k] + 8'd1 ||
          log_d2[c+1+k] !== e0[k] + 8'd2) begin
        n_err++;
        $display("FAIL b2b_window%0d: got %0d/%0d/%0d required %0d/%0d/%0d",
                 k, log_d0[c-1+k], log_d1[c+k], log_d2[c+1+k],
                 e0[k], e0[k] + 8'd1, e0[k] + 8'd2);
      end
    end
    n_cmp++;
    if (log_d1[c-1] !== 8'd0 || log_d2[c] !== 8'd0 || log_d2[c+4] !== 8'd0) begin
      n_err++;
      $display("FAIL b2b_idle_taps: got %0d/%0d/%0d required 0/0/0",
               log_d1[c-1], log_d2[c], log_d2[c+4]);
    end
    n_cmp++;
    if (log_done[c+3] !== 1'b0 || log_done[c+4] !== 1'b1 ||
        log_busy[c+3] !== 1'b1 || log_busy[c+4] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done_timing: done %b%b busy %b%b required 01 10",
               log_done[c+3], log_done[c+4], log_busy[c+3], log_busy[c+4]);
    end
    nd = 0;
    for (int t = t0; t < cyc; t++) nd += int'(log_done[t % 4096]);
    n_cmp++;
    if (nd != 1) begin
      n_err++;
      $display("FAIL b2b_done_count: got %0d required 1", nd);
    end
    n_cmp++;
    if (pq.size() != 3 || pq[0] !== 16'd14 || pq[1] !== 16'd20 ||
        pq[2] !== 16'd26) begin
      n_err++;
      $display("FAIL b2b_psum: got size %0d first %0d required 14,20,26",
               pq.size(), pq.size() > 0 ? pq[0] : 16'd0);
    end
  endtask

  task automatic test_bubbles;
    int c;
    int t0;
    int nv;
    int bad;
    t0 = cyc;
    pq.delete();
    run_job(8'd1, 8'd2, 8'd3, 5, 1'b1, 1'b0, 5, c);
    tick(8);
    nv = 0;
    bad = 0;
    for (int t = t0; t < cyc; t++) begin
      nv += int'(log_v[t % 4096]);
      if (!log_v[t % 4096] && log_d0[t % 4096] != 8'd0) bad++;
      if (log_v[t % 4096] && log_v[(t + 1) % 4096]) bad++;
    end
    n_cmp++;
    if (nv != 3 || bad != 0) begin
      n_err++;
      $display("FAIL bubble_valid: windows %0d gap_violations %0d required 3 0",
               nv, bad);
    end
    n_cmp++;
    if (pq.size() != 3 || pq[0] !== 16'd14 || pq[1] !== 16'd20 ||
        pq[2] !== 16'd26) begin
      n_err++;
      $display("FAIL bubble_psum: got size %0d required 14,20,26", pq.size());
    end
  endtask

  task automatic test_short_len;
    bit saw_ready;
    bit saw_busy;
    start = 1'b1;
    length = 8'd2;
    w_valid = 1'b1;
    x_valid = 1'b1;
    tick(1);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL short_done: done %b busy %b required 1 0", done, busy);
    end
    saw_ready = w_ready | x_ready;
    saw_busy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      saw_ready |= w_ready | x_ready;
      saw_busy |= busy | done;
    end
    w_valid = 1'b0;
    x_valid = 1'b0;
    n_cmp++;
    if (saw_ready || saw_busy) begin
      n_err++;
      $display("FAIL short_quiet: ready %b busy/done %b required 0 0",
               saw_ready, saw_busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int c;
    run_job(8'd9, 8'd9, 8'd9, 8, 1'b0, 1'b0, 4, c);
    n_cmp++;
    if (sa_valid_in !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_active: valid %b busy %b required 1 1",
               sa_valid_in, busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sa_valid_in, sa_data_in0, sa_data_in1, sa_data_in2, sa_weight_in0,
         sa_weight_in1, sa_weight_in2, busy, done, w_ready, x_ready} !== '0) begin
      n_err++;
      $display("FAIL async_reset: outputs nonzero right after rst");
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    pq.delete();
    run_job(8'd2, 8'd0, 8'd1, 4, 1'b0, 1'b0, 4, c);
    tick(8);
    n_cmp++;
    if (pq.size() != 2 || pq[0] !== 16'd5 || pq[1] !== 16'd8) begin
      n_err++;
      $display("FAIL post_reset_psum: got size %0d required 5,8", pq.size());
    end
  endtask

  task automatic test_ignore_noise;
    int c;
    int t0;
    int nd;
    t0 = cyc;
    pq.delete();
    run_job(8'd1, 8'd2, 8'd3, 5, 1'b0, 1'b1, 5, c);
    tick(8);
    n_cmp++;
    if (sa_weight_in0 !== 8'd1 || sa_weight_in1 !== 8'd2 ||
        sa_weight_in2 !== 8'd3) begin
      n_err++;
      $display("FAIL noise_weights: got %0d,%0d,%0d required 1,2,3",
               sa_weight_in0, sa_weight_in1, sa_weight_in2);
    end
    nd = 0;
    for (int t = t0; t < cyc; t++) nd += int'(log_done[t % 4096]);
    n_cmp++;
    if (nd != 1 || pq.size() != 3 || pq[0] !== 16'd14 || pq[2] !== 16'd26) begin
      n_err++;
      $display("FAIL noise_job: done %0d windows %0d required 1 3",
               nd, pq.size());
    end
  endtask

  task automatic test_max_len;
    int c;
    int t0;
    int nv;
    int bad;
    t0 = cyc;
    pq.delete();
    run_job(8'd1, 8'd2, 8'd3, 255, 1'b0, 1'b0, 255, c);
    tick(8);
    nv = 0;
    for (int t = t0; t < cyc; t++) nv += int'(log_v[t % 4096]);
    n_cmp++;
    if (nv != 253) begin
      n_err++;
      $display("FAIL max_windows: got %0d required 253", nv);
    end
    n_cmp++;
    if (log_done[(c+4) % 4096] !== 1'b1 || log_busy[(c+3) % 4096] !== 1'b1) begin
      n_err++;
      $display("FAIL max_done_timing: done %b busy %b required 1 1",
               log_done[(c+4) % 4096], log_busy[(c+3) % 4096]);
    end
    bad = 0;
    foreach (pq[k]) if (pq[k] !== 16'(6 * k + 14)) bad++;
    n_cmp++;
    if (pq.size() != 253 || bad != 0) begin
      n_err++;
      $display("FAIL max_psum: size %0d wrong %0d required 253 0",
               pq.size(), bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    length = '0;
    w_valid = 1'b0;
    w_data = '0;
    x_valid = 1'b0;
    x_data = '0;
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_short_len();
    test_reset_mid_run();
    test_ignore_noise();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
